garage_door_ctrl: RTL and testbench

GARAGE_DOOR_CTRL -- requirements
Module: garage_door_ctrl

---
 rtl/garage_door_ctrl.sv | 126 ++++++++++++
 tb/tb_garage_door_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/garage_door_ctrl.sv
// Garage door controller: Moore FSM driving raise/lower motors from a push button,
// two limit switches and an obstruction beam, with travel timeout and auto-close dwell.
module garage_door_ctrl #(
  parameter int unsigned MAX_TRAVEL = 64,
  parameter int unsigned AUTO_CLOSE = 32,
  parameter int unsigned CNT_W      = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Activate,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Obstr,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] Door_State
);

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    MV_UP   = 3'd1,
    OPEN    = 3'd2,
    MV_DN   = 3'd3,
    STOPPED = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(MAX_TRAVEL - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST  = CNT_W'(AUTO_CLOSE - 1);

  state_t           state, state_nxt;
  logic             last_up, last_up_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             act_q;
  logic             act_blk;
  logic             act_edge;
  logic             both_lim;
  logic             travel_exp;
  logic             dwell_exp;

  // act_blk suppresses the edge of a button still held when reset is released
  always_comb begin
    act_edge   = Activate && !act_q && !act_blk;
    both_lim   = UP_Max && DN_Max;
    travel_exp = (cnt == TRAVEL_LAST);
    dwell_exp  = (AUTO_CLOSE != 0) && (cnt == DWELL_LAST);
  end

  always_comb begin
    state_nxt   = state;
    last_up_nxt = last_up;
    case (state)
      CLOSED: begin
        if (both_lim)      state_nxt = FAULT;
        else if (act_edge) state_nxt = MV_UP;
      end
      STOPPED: begin
        if (both_lim)      state_nxt = FAULT;
        else if (DN_Max)   state_nxt = CLOSED;
        else if (UP_Max)   state_nxt = OPEN;
        else if (act_edge) state_nxt = last_up ? MV_DN : MV_UP;
      end
      MV_UP: begin
        if (both_lim)        state_nxt = FAULT;
        else if (UP_Max)     state_nxt = OPEN;
        else if (travel_exp) state_nxt = FAULT;
        else if (act_edge) begin
          state_nxt   = STOPPED;
          last_up_nxt = 1'b1;
        end
      end
      MV_DN: begin
        if (both_lim)        state_nxt = FAULT;
        else if (DN_Max)     state_nxt = CLOSED;
        else if (Obstr)      state_nxt = MV_UP;
        else if (travel_exp) state_nxt = FAULT;
        else if (act_edge) begin
          state_nxt   = STOPPED;
          last_up_nxt = 1'b0;
        end
      end
      OPEN: begin
        if (both_lim)                state_nxt = FAULT;
        else if (Obstr)              state_nxt = OPEN;
        else if (act_edge)           state_nxt = MV_DN;
        else if (dwell_exp)          state_nxt = MV_DN;
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  // Counter runs only while staying in a timed state; any entry restarts it at 0
  always_comb begin
    cnt_nxt = '0;
    if ((state_nxt == state) &&
        (state == MV_UP || state == MV_DN || (state == OPEN && !Obstr))) begin
      cnt_nxt = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= STOPPED;
      last_up <= 1'b1;
      cnt     <= '0;
      act_q   <= 1'b0;
      act_blk <= Activate;
    end else begin
      state   <= state_nxt;
      last_up <= last_up_nxt;
      cnt     <= cnt_nxt;
      act_q   <= Activate;
      if (!Activate) act_blk <= 1'b0;
    end
  end

  always_comb begin
    UP_M       = (state == MV_UP);
    DN_M       = (state == MV_DN);
    Fault      = (state == FAULT);
    Door_State = state;
  end

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Bench for garage_door_ctrl: directed vector table plus randomized stimulus
// checked against an elapsed-time reference model of the door behaviour.
module tb_garage_door_ctrl;

  localparam int MAX_T = 8;
  localparam int AC    = 4;

  logic       CLK = 1'b0;
  logic       RST, Activate, UP_Max, DN_Max, Obstr;
  logic       UP_M, DN_M, Fault;
  logic [2:0] Door_State;

  garage_door_ctrl #(.MAX_TRAVEL(MAX_T), .AUTO_CLOSE(AC)) dut (
    .CLK(CLK), .RST(RST), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
    .Obstr(Obstr), .UP_M(UP_M), .DN_M(DN_M), .Fault(Fault), .Door_State(Door_State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic rst, act, up, dn, ob;
    int   st;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: state code plus cycle stamp of the last (re)entry
  int cyc = 0;
  int m_st = 4;
  int m_entry = 0;
  bit m_last_up = 1'b1;
  bit m_prev = 1'b0;

  function automatic void enter(int s);
    m_st = s;
    m_entry = cyc;
  endfunction

  function automatic void model_step(bit r, bit a, bit u, bit d, bit o);
    bit ed;
    int el;
    cyc++;
    if (r) begin
      m_st = 4; m_last_up = 1'b1; m_entry = cyc; m_prev = a;
      return;
    end
    ed = a && !m_prev;
    m_prev = a;
    el = cyc - m_entry;
    if (m_st != 5 && u && d) m_st = 5;
    else begin
      case (m_st)
        0: if (ed) enter(1);
        4: begin
          if (d) m_st = 0;
          else if (u) enter(2);
          else if (ed) enter(m_last_up ? 3 : 1);
        end
        1: begin
          if (u) enter(2);
          else if (el >= MAX_T) m_st = 5;
          else if (ed) begin m_st = 4; m_last_up = 1'b1; end
        end
        3: begin
          if (d) m_st = 0;
          else if (o) enter(1);
          else if (el >= MAX_T) m_st = 5;
          else if (ed) begin m_st = 4; m_last_up = 1'b0; end
        end
        2: begin
          if (o) m_entry = cyc;
          else if (ed) enter(3);
          else if (AC > 0 && el >= AC) enter(3);
        end
        default: m_st = 5;
      endcase
    end
  endfunction

  function automatic logic [5:0] outs_of(int s);
    return {s[2:0], s == 1, s == 3, s == 5};
  endfunction

  task automatic compare(input string name, input int s);
    logic [5:0] got, want;
    got  = {Door_State, UP_M, DN_M, Fault};
    want = outs_of(s);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got {state,up,dn,fault}=%b, want %b", name, cyc, got, want);
    end
  endtask

  task automatic step(input logic r, a, u, d, o, input int exp_st);
    RST = r; Activate = a; UP_Max = u; DN_Max = d; Obstr = o;
    model_step(r, a, u, d, o);
    @(posedge CLK);
    #1;
    compare("model", m_st);
    if (exp_st >= 0) compare("table", exp_st);
    n_checks++;
    if (UP_M && DN_M) begin
      n_errors++;
      $display("FAIL motors_exclusive cyc=%0d: got UP_M=1 DN_M=1, want not both", cyc);
    end
  endtask

  function automatic void add(logic r, a, u, d, o, int s);
    vec_t v;
    v.rst = r; v.act = a; v.up = u; v.dn = d; v.ob = o; v.st = s;
    vecs.push_back(v);
  endfunction

  initial begin
    logic a, u, d, o, r;
    RST = 1'b1; Activate = 1'b0; UP_Max = 1'b0; DN_Max = 1'b0; Obstr = 1'b0;

    // reset, close on DN_Max, open run to UP_Max
    add(1,0,0,0,0, 4);
    add(0,0,0,1,0, 0);
    add(0,1,0,1,0, 1);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0, 1);
    add(0,0,1,0,0, 2);
    // auto-close after 4 open cycles, obstruction reversal, travel timeout
    for (int i = 0; i < 3; i++) add(0,0,1,0,0, 2);
    add(0,0,1,0,0, 3);
    add(0,0,0,0,0, 3);
    add(0,0,0,0,1, 1);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0, 1);
    add(0,0,0,0,0, 5);
    add(0,1,0,0,0, 5);
    add(0,0,0,0,0, 5);
    add(0,1,0,0,0, 5);
    add(1,0,0,0,0, 4);
    // stop/reverse via Activate, held Activate gives one transition
    add(0,1,0,0,0, 3);
    add(0,0,0,0,0, 3);
    add(0,1,0,0,0, 4);
    add(0,0,0,0,0, 4);
    for (int i = 0; i < 5; i++) add(0,1,0,0,0, 1);
    add(0,1,1,0,0, 2);
    for (int i = 0; i < 4; i++) add(0,1,1,0,1, 2);
    for (int i = 0; i < 6; i++) add(0,i[0],1,0,1, 2);
    // both limits -> fault from several states
    add(0,0,1,1,0, 5);
    add(1,0,0,0,0, 4);
    add(0,0,1,1,0, 5);
    add(1,0,0,0,0, 4);
    add(0,0,0,1,0, 0);
    add(0,0,1,1,0, 5);
    // Activate held through reset release
    add(1,1,0,0,0, 4);
    add(0,1,0,0,0, 4);
    add(0,0,0,0,0, 4);
    add(0,1,0,0,0, 3);
    add(0,0,0,0,0, 3);
    add(0,0,1,1,0, 5);
    add(1,0,0,0,0, 4);
    // priority of limits/obstruction over Activate
    add(0,1,0,0,0, 3);
    add(0,0,0,1,1, 0);
    add(0,1,0,0,1, 1);
    add(0,1,1,0,0, 2);
    add(0,0,1,0,0, 2);
    add(0,1,0,0,0, 3);
    add(0,0,0,0,0, 3);
    add(0,1,0,0,1, 1);
    add(0,0,0,0,0, 1);
    add(1,0,0,0,0, 4);
    // MV_DN travel timeout
    add(0,1,0,0,0, 3);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0, 3);
    add(0,0,0,0,0, 5);
    add(1,0,0,0,0, 4);

    foreach (vecs[i])
      step(vecs[i].rst, vecs[i].act, vecs[i].up, vecs[i].dn, vecs[i].ob, vecs[i].st);

    a = 1'b0;
    step(1,0,0,0,0, 4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) a = ~a;
      u = ($urandom_range(0, 15) == 0);
      d = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 5) == 0);
      r = ($urandom_range(0, 63) == 0);
      step(r, a, u, d, o, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
